hamming_secded_codec: RTL

- Parametrised, pipelined Hamming codec with a valid/ready stream interface.
- Each beat is tagged as encode or decode.
- Encode: DATA_W data bits in, Hamming codeword out, with an optional overall-parity bit (SECDED).
- Decode: corrects single errors, flags double or uncorrectable errors, and keeps saturating error counters for the link-health status logic.

---
 rtl/hamming_pkg.sv | 41 ++++
 rtl/hamming_parity_gen.sv | 50 +++++
 rtl/hamming_secded_codec.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming SEC/SECDED codec.
// Provides the beat mode type and the elaboration-time helpers that
// describe the code layout (parity-bit count, power-of-two test,
// data-bit position lookup). Positions are 1-based: code[i] holds position i+1.
package hamming_pkg;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int unsigned calc_r(input int unsigned data_w);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < 31; i++) begin
      if (r == 0 && (32'd1 << i) >= data_w + i + 1) r = i;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Position of data bit k: the (k+1)-th position that is not a power of two.
  function automatic int unsigned data_pos(input int unsigned k);
    int unsigned cnt;
    int unsigned res;
    cnt = 0;
    res = 0;
    for (int unsigned p = 3; p < 4096; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == k && res == 0) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming parity generator.
// Places the data bits at their non-power-of-two positions, computes the
// R parity bits and inserts them at the power-of-two positions.
// Ports:
//   data_i    - DATA_W data bits
//   code_o    - N-bit Hamming codeword (no overall parity)
//   parity_o  - the R parity bits (parity_o[j] belongs to position 2^j)
//   all_xor_o - XOR of all N codeword bits (overall parity for SECDED)
module hamming_parity_gen
  import hamming_pkg::*;
#(
  parameter  int unsigned DATA_W = 7,
  localparam int unsigned R      = calc_r(DATA_W),
  localparam int unsigned N      = DATA_W + R
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [N-1:0]      code_o,
  output logic [R-1:0]      parity_o,
  output logic              all_xor_o
);

  // Data bits in place, parity positions held at zero.
  logic [N-1:0] dcode;

  for (genvar k = 0; k < DATA_W; k++) begin : g_data
    assign dcode[data_pos(k)-1] = data_i[k];
  end
  for (genvar j = 0; j < R; j++) begin : g_pzero
    assign dcode[(1 << j)-1] = 1'b0;
  end

  always_comb begin
    parity_o = '0;
    for (int unsigned p = 1; p <= N; p++) begin
      for (int unsigned j = 0; j < R; j++) begin
        if (((p >> j) & 1) != 0) parity_o[j] = parity_o[j] ^ dcode[p-1];
      end
    end
  end

  always_comb begin
    code_o = dcode;
    for (int unsigned j = 0; j < R; j++) begin
      code_o[(1 << j)-1] = parity_o[j];
    end
  end

  assign all_xor_o = ^code_o;

endmodule

// File: rtl/hamming_secded_codec.sv
// Pipelined Hamming SEC/SECDED encoder/decoder with valid/ready streaming.
// Each beat is tagged encode or decode. S1 registers the beat with its
// syndrome and overall-parity check; S2 applies correction and registers
// the outputs. Saturating counters track corrected and uncorrectable
// decode beats at the output handshake.
// Ports:
//   clk, areset_n          - clock, synchronous active-low reset
//   in_valid/in_ready      - input handshake; in_mode 0=encode 1=decode
//   in_word                - decode: codeword; encode: data in low DATA_W bits
//   out_valid/out_ready    - output handshake; out_mode echoes the beat mode
//   out_code, out_data     - codeword / (corrected) data
//   out_syndrome           - decode syndrome, 0 for encode
//   out_err_single/_double - corrected / uncorrectable flags
//   cnt_clear, cnt_corr, cnt_uncorr - error counters and their clear
module hamming_secded_codec
  import hamming_pkg::*;
#(
  parameter  int unsigned DATA_W = 7,
  parameter  int unsigned SECDED = 1,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned R      = calc_r(DATA_W),
  localparam int unsigned N      = DATA_W + R,
  localparam int unsigned CODE_W = N + SECDED
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [CODE_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mode,
  output logic [CODE_W-1:0] out_code,
  output logic [DATA_W-1:0] out_data,
  output logic [R-1:0]      out_syndrome,
  output logic              out_err_single,
  output logic              out_err_double,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  localparam logic [R-1:0] N_R = R'(N);

  // ---------------- front end: encode and syndrome ----------------
  logic [N-1:0]      enc_code, dec_code;
  logic [R-1:0]      enc_par, dec_par;
  logic              enc_all, dec_all;
  logic [CODE_W-1:0] enc_word;
  logic [DATA_W-1:0] rx_data;
  logic [R-1:0]      rx_par;
  logic [R-1:0]      syn;
  logic              pmis;

  hamming_parity_gen #(.DATA_W(DATA_W)) u_enc (
    .data_i    (in_word[DATA_W-1:0]),
    .code_o    (enc_code),
    .parity_o  (enc_par),
    .all_xor_o (enc_all)
  );

  for (genvar k = 0; k < DATA_W; k++) begin : g_rx_data
    assign rx_data[k] = in_word[data_pos(k)-1];
  end
  for (genvar j = 0; j < R; j++) begin : g_rx_par
    assign rx_par[j] = in_word[(1 << j)-1];
  end

  // Recomputing parity over the received data and comparing with the
  // received parity bits yields the syndrome.
  hamming_parity_gen #(.DATA_W(DATA_W)) u_dec (
    .data_i    (rx_data),
    .code_o    (dec_code),
    .parity_o  (dec_par),
    .all_xor_o (dec_all)
  );

  assign syn = dec_par ^ rx_par;

  if (SECDED != 0) begin : g_secded
    assign enc_word = {enc_all, enc_code};
    assign pmis     = ^in_word;
  end else begin : g_sec
    assign enc_word = enc_code;
    assign pmis     = 1'b0;
  end

  logic unused_sig;
  assign unused_sig = ^{enc_par, dec_code, dec_all, enc_all};

  // ---------------- pipeline state ----------------
  logic              s1_valid_q, s1_valid_d;
  mode_e             s1_mode_q, s1_mode_d;
  logic [CODE_W-1:0] s1_word_q, s1_word_d;
  logic [R-1:0]      s1_syn_q, s1_syn_d;
  logic              s1_pmis_q, s1_pmis_d;

  logic              out_valid_q, out_valid_d;
  mode_e             out_mode_q, out_mode_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [R-1:0]      out_syn_q, out_syn_d;
  logic              out_single_q, out_single_d;
  logic              out_double_q, out_double_d;

  logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;

  logic adv_s1, adv_s2, out_fire;

  assign adv_s2   = !out_valid_q || out_ready;
  assign adv_s1   = !s1_valid_q || adv_s2;
  assign out_fire = out_valid_q && out_ready;

  // ---------------- S2 correction ----------------
  logic [CODE_W-1:0] flip;
  logic [CODE_W-1:0] corr_word;
  logic [DATA_W-1:0] corr_data;
  logic              c_single, c_double;

  always_comb begin
    flip     = '0;
    c_single = 1'b0;
    c_double = 1'b0;
    if (s1_mode_q == MODE_DEC) begin
      if (SECDED != 0 && s1_pmis_q && s1_syn_q == '0) begin
        // Only the overall parity bit is wrong.
        flip[CODE_W-1] = 1'b1;
        c_single       = 1'b1;
      end else if (s1_syn_q != '0 && (SECDED == 0 || s1_pmis_q) && s1_syn_q <= N_R) begin
        flip     = CODE_W'(1) << (s1_syn_q - R'(1));
        c_single = 1'b1;
      end else if (s1_syn_q != '0) begin
        c_double = 1'b1;
      end
    end
  end

  assign corr_word = s1_word_q ^ flip;

  // For encode beats flip is zero, so this recovers the input data.
  for (genvar k = 0; k < DATA_W; k++) begin : g_corr_data
    assign corr_data[k] = corr_word[data_pos(k)-1];
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_word_d  = s1_word_q;
    s1_syn_d   = s1_syn_q;
    s1_pmis_d  = s1_pmis_q;
    if (adv_s1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mode_d = in_mode ? MODE_DEC : MODE_ENC;
        s1_word_d = in_mode ? in_word : enc_word;
        s1_syn_d  = in_mode ? syn : '0;
        s1_pmis_d = in_mode ? pmis : 1'b0;
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_mode_d   = out_mode_q;
    out_code_d   = out_code_q;
    out_data_d   = out_data_q;
    out_syn_d    = out_syn_q;
    out_single_d = out_single_q;
    out_double_d = out_double_q;
    if (adv_s2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_mode_d   = s1_mode_q;
        out_code_d   = corr_word;
        out_data_d   = corr_data;
        out_syn_d    = s1_syn_q;
        out_single_d = c_single;
        out_double_d = c_double;
      end
    end
  end

  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (cnt_clear) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else if (out_fire && out_mode_q == MODE_DEC) begin
      if (out_single_q && cnt_corr_q != '1) cnt_corr_d = cnt_corr_q + CNT_W'(1);
      if (out_double_q && cnt_uncorr_q != '1) cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= MODE_ENC;
      s1_word_q    <= '0;
      s1_syn_q     <= '0;
      s1_pmis_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_mode_q   <= MODE_ENC;
      out_code_q   <= '0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_single_q <= 1'b0;
      out_double_q <= 1'b0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_word_q    <= s1_word_d;
      s1_syn_q     <= s1_syn_d;
      s1_pmis_q    <= s1_pmis_d;
      out_valid_q  <= out_valid_d;
      out_mode_q   <= out_mode_d;
      out_code_q   <= out_code_d;
      out_data_q   <= out_data_d;
      out_syn_q    <= out_syn_d;
      out_single_q <= out_single_d;
      out_double_q <= out_double_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign in_ready       = adv_s1;
  assign out_valid      = out_valid_q;
  assign out_mode       = out_mode_q;
  assign out_code       = out_code_q;
  assign out_data       = out_data_q;
  assign out_syndrome   = out_syn_q;
  assign out_err_single = out_single_q;
  assign out_err_double = out_double_q;
  assign cnt_corr       = cnt_corr_q;
  assign cnt_uncorr     = cnt_uncorr_q;

endmodule
